mod_switch_div: RTL and testbench

MOD_SWITCH_DIV -- requirements
Module: mod_switch_div

---
 rtl/mod_switch_div.sv | 169 ++++++++++++++++
 tb/tb_mod_switch_div.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_switch_div.sv
`default_nettype none
// ============================================================================
//  Module   : mod_switch_div
//  Purpose  : Modulus switch from an odd modulus MOD_M to 2**Q_W.
//             Computes z = ((floor(x * 2**(Q_W+1) / MOD_M) + 1) >> 1) mod 2**Q_W
//             (round half up) with a bit-serial restoring divider, one
//             quotient bit per cycle, MSB first.
//  Ports    : clk       - clock, rising edge
//             s_rst     - synchronous active-high reset
//             x         - input residue in [0, MOD_M)
//             in_avail  - x / in_side valid
//             in_rdy    - block accepts input this cycle
//             in_side   - side data carried alongside x
//             z         - switched result (held between results)
//             out_avail - one-cycle pulse, z / out_side valid
//             out_side  - in_side of the same transaction
//  Timing   : transfer in cycle T -> out_avail in cycle T+Q_W+2,
//             one result every Q_W+3 cycles, no output backpressure.
//  Options  : MOD_SWITCH_DIV_CHECK_EN - compiles in simulation checks
//             (out-of-range x is fatal, final remainder must be < MOD_M).
//  Revision : 1.0 - initial release
// ============================================================================
module mod_switch_div #(
   parameter int               MOD_W    = 32,
   parameter logic [MOD_W-1:0] MOD_M    = MOD_W'((65'd1 << MOD_W) - (65'd1 << (MOD_W / 2)) + 65'd1),
   parameter int               Q_W      = 32,
   parameter int               SIDE_W   = 0,
   parameter logic [1:0]       RST_SIDE = 2'b00
) (
   input  logic                                   clk,
   input  logic                                   s_rst,
   input  logic [MOD_W-1:0]                       x,
   input  logic                                   in_avail,
   output logic                                   in_rdy,
   input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
   output logic [Q_W-1:0]                         z,
   output logic                                   out_avail,
   output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

   // A zero-width side channel is carried as a single unused bit.
   localparam int                SW      = (SIDE_W > 0) ? SIDE_W : 1;
   localparam int                CNT_W   = $clog2(Q_W + 2);
   localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(Q_W);
   localparam logic [MOD_W:0]    MOD_X   = {1'b0, MOD_M};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [MOD_W:0]   r_q,     r_d;
   logic [Q_W:0]     q_q,     q_d;
   logic [Q_W-1:0]   z_q,     z_d;
   logic [SW-1:0]    side_q;

   logic             w_take;
   logic [MOD_W:0]   w_r2;
   logic             w_ge;
   logic [MOD_W:0]   w_r_next;
   logic [Q_W:0]     w_q_next;
   logic [Q_W+1:0]   w_round;
   logic             w_unused_round;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   assign in_rdy    = (state_q == ST_IDLE) && !s_rst;
   assign out_avail = (state_q == ST_DONE) && !s_rst;
   assign w_take    = in_rdy && in_avail;

   // ------------------------------------------------------------------------
   // One restoring-division step
   // ------------------------------------------------------------------------
   assign w_r2     = r_q << 1;
   assign w_ge     = (w_r2 >= MOD_X);
   assign w_r_next = w_ge ? (w_r2 - MOD_X) : w_r2;
   assign w_q_next = {q_q[Q_W-1:0], w_ge};

   // Rounding add on the completed quotient; bit 0 is shifted away and the
   // carry-out is dropped, so (q+1)>>1 wraps to zero at 2**Q_W.
   assign w_round        = {1'b0, w_q_next} + {{(Q_W+1){1'b0}}, 1'b1};
   assign w_unused_round = ^{w_round[Q_W+1], w_round[0]};

   // ------------------------------------------------------------------------
   // Next-state / datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE: begin
            if (w_take) begin
               state_d = ST_DIV;
               cnt_d   = '0;
               r_d     = {1'b0, x};
               q_d     = '0;
            end
         end
         ST_DIV: begin
            r_d   = w_r_next;
            q_d   = w_q_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) begin
               state_d = ST_DONE;
               z_d     = w_round[Q_W:1];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         z_q     <= z_d;
      end
   end

   // Side data: reset value selectable, left unreset when RST_SIDE is 0.
   always_ff @(posedge clk) begin
      if (s_rst && RST_SIDE[0]) begin
         side_q <= '0;
      end else if (s_rst && RST_SIDE[1]) begin
         side_q <= '1;
      end else if (w_take) begin
         side_q <= in_side;
      end
   end

   assign z        = z_q;
   assign out_side = side_q;

`ifdef MOD_SWITCH_DIV_CHECK_EN
   always_ff @(posedge clk) begin
      if (!s_rst) begin
         if (w_take && (x >= MOD_M)) begin
            $fatal(1, "mod_switch_div: input x=%0d not below modulus %0d", x, MOD_M);
         end
         if ((state_q == ST_DIV) && (cnt_q == LAST_IT)) begin
            assert (w_r_next < MOD_X)
               else $error("mod_switch_div: final remainder %0d not below modulus", w_r_next);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_switch_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_switch_div
//  Purpose  : Directed self-checking bench for mod_switch_div.
//             dut_a : MOD_W=5, MOD_M=17, Q_W=4, SIDE_W=8, side reset to 0
//             dut_b : MOD_W=5, MOD_M=17, Q_W=3 (rounding wrap case)
//             dut_c : default parameters (32-bit residue, 32-bit result)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_switch_div;

   logic        clk = 1'b0;
   logic        s_rst;

   logic [4:0]  x_a;
   logic        av_a;
   logic        rdy_a;
   logic [7:0]  side_a;
   logic [3:0]  z_a;
   logic        oav_a;
   logic [7:0]  oside_a;

   logic [4:0]  x_b;
   logic        av_b;
   logic        rdy_b;
   logic        side_b;
   logic [2:0]  z_b;
   logic        oav_b;
   logic        oside_b;

   logic [31:0] x_c;
   logic        av_c;
   logic        rdy_c;
   logic        side_c;
   logic [31:0] z_c;
   logic        oav_c;
   logic        oside_c;

   int          nvec  = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   mod_switch_div #(
      .MOD_W(5), .MOD_M(5'd17), .Q_W(4), .SIDE_W(8), .RST_SIDE(2'b01)
   ) dut_a (
      .clk(clk), .s_rst(s_rst), .x(x_a), .in_avail(av_a), .in_rdy(rdy_a),
      .in_side(side_a), .z(z_a), .out_avail(oav_a), .out_side(oside_a)
   );

   mod_switch_div #(
      .MOD_W(5), .MOD_M(5'd17), .Q_W(3)
   ) dut_b (
      .clk(clk), .s_rst(s_rst), .x(x_b), .in_avail(av_b), .in_rdy(rdy_b),
      .in_side(side_b), .z(z_b), .out_avail(oav_b), .out_side(oside_b)
   );

   mod_switch_div dut_c (
      .clk(clk), .s_rst(s_rst), .x(x_c), .in_avail(av_c), .in_rdy(rdy_c),
      .in_side(side_c), .z(z_c), .out_avail(oav_c), .out_side(oside_c)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic av, input logic [31:0] xv, input logic [7:0] sv);
      case (sel)
         0:       begin av_a = av; x_a = xv[4:0]; side_a = sv; end
         1:       begin av_b = av; x_b = xv[4:0]; end
         default: begin av_c = av; x_c = xv; end
      endcase
   endtask

   function automatic logic get_rdy(input int sel);
      case (sel)
         0:       return rdy_a;
         1:       return rdy_b;
         default: return rdy_c;
      endcase
   endfunction

   function automatic logic get_oav(input int sel);
      case (sel)
         0:       return oav_a;
         1:       return oav_b;
         default: return oav_c;
      endcase
   endfunction

   function automatic logic [31:0] get_z(input int sel);
      case (sel)
         0:       return {28'd0, z_a};
         1:       return {29'd0, z_b};
         default: return z_c;
      endcase
   endfunction

   // One transaction: transfer in cycle T, measure latency to out_avail,
   // check result, then check the pulse ends, z holds and in_rdy returns.
   // With inj set, a stray in_avail with x=3 is offered in cycle T+2.
   task automatic run_txn(input int sel, input logic [31:0] xv, input logic [7:0] sv,
                          input logic [31:0] ez, input int elat, input bit inj,
                          input string tag);
      int lat;
      check({tag, ".rdy_before"}, {63'd0, get_rdy(sel)}, 64'd1);
      drive(sel, 1'b1, xv, sv);
      @(negedge clk);
      drive(sel, 1'b0, xv, sv);
      lat = 1;
      while (!get_oav(sel) && lat < 200) begin
         @(negedge clk);
         lat++;
         if (inj && lat == 2) drive(sel, 1'b1, 32'd3, 8'h3C);
         else                 drive(sel, 1'b0, xv, sv);
      end
      check({tag, ".latency"}, 64'(lat), 64'(elat));
      check({tag, ".z"}, {32'd0, get_z(sel)}, {32'd0, ez});
      if (sel == 0) check({tag, ".side"}, {56'd0, oside_a}, {56'd0, sv});
      @(negedge clk);
      check({tag, ".pulse_end"}, {63'd0, get_oav(sel)}, 64'd0);
      check({tag, ".z_hold"}, {32'd0, get_z(sel)}, {32'd0, ez});
      check({tag, ".rdy_after"}, {63'd0, get_rdy(sel)}, 64'd1);
   endtask

   initial begin
      logic [4:0] xs [4];
      logic [3:0] ezs [4];
      int         acc [4];
      int         ai;
      int         oi;
      bit         pend;
      bit         seen;
      bit         zbad;

      xs  = '{5'd0, 5'd1, 5'd9, 5'd16};
      ezs = '{4'd0, 4'd1, 4'd8, 4'd15};

      s_rst  = 1'b1;
      av_a   = 1'b0; x_a = '0; side_a = '0;
      av_b   = 1'b0; x_b = '0; side_b = 1'b0;
      av_c   = 1'b0; x_c = '0; side_c = 1'b0;

      // ---------------- reset state ----------------
      @(negedge clk);
      @(negedge clk);
      check("rst.rdy_a",  {63'd0, rdy_a},   64'd0);
      check("rst.oav_a",  {63'd0, oav_a},   64'd0);
      check("rst.z_a",    {60'd0, z_a},     64'd0);
      check("rst.side_a", {56'd0, oside_a}, 64'd0);
      check("rst.rdy_c",  {63'd0, rdy_c},   64'd0);
      check("rst.z_c",    {32'd0, z_c},     64'd0);
      s_rst = 1'b0;
      #1;
      check("rst.rdy_first_a", {63'd0, rdy_a}, 64'd1);
      check("rst.rdy_first_b", {63'd0, rdy_b}, 64'd1);

      // ---------------- single transactions, Q_W=4 ----------------
      run_txn(0, 32'd8, 8'hA5, 32'd8, 6, 1'b1, "a.x8_inj");
      run_txn(0, 32'd1, 8'h5A, 32'd1, 6, 1'b0, "a.x1");
      run_txn(0, 32'd16, 8'hFF, 32'd15, 6, 1'b0, "a.x16");

      // ---------------- back-to-back with in_avail held ----------------
      ai = 0; oi = 0; pend = 1'b0;
      drive(0, 1'b1, {27'd0, xs[0]}, 8'h11);
      for (int c = 0; c < 80 && oi < 4; c++) begin
         if (pend) begin
            pend = 1'b0;
            if (ai < 4) drive(0, 1'b1, {27'd0, xs[ai]}, 8'h11);
            else        drive(0, 1'b0, 32'd0, 8'h11);
         end
         if (oav_a) begin
            check($sformatf("b2b.z%0d", oi), {60'd0, z_a}, {60'd0, ezs[oi]});
            check($sformatf("b2b.lat%0d", oi), 64'(c - acc[oi]), 64'd6);
            oi++;
         end
         if (rdy_a && av_a && ai < 4) begin
            acc[ai] = c;
            ai++;
            pend = 1'b1;
         end
         @(negedge clk);
      end
      drive(0, 1'b0, 32'd0, 8'h00);
      check("b2b.outputs", 64'(oi), 64'd4);
      check("b2b.accepts", 64'(ai), 64'd4);
      for (int i = 1; i < 4; i++) begin
         check($sformatf("b2b.spacing%0d", i), 64'(acc[i] - acc[i-1]), 64'd7);
      end

      // ---------------- reset abort in the middle of DIV ----------------
      @(negedge clk);
      drive(0, 1'b1, 32'd8, 8'h77);
      @(negedge clk);                 // T+1
      drive(0, 1'b0, 32'd8, 8'h77);
      @(negedge clk);                 // T+2
      @(negedge clk);                 // T+3
      s_rst = 1'b1;
      @(negedge clk);                 // T+4
      s_rst = 1'b0;
      seen = 1'b0;
      zbad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (oav_a)        seen = 1'b1;
         if (z_a !== 4'd0) zbad = 1'b1;
         @(negedge clk);
      end
      check("abort.no_pulse", {63'd0, seen}, 64'd0);
      check("abort.z_zero",   {63'd0, zbad}, 64'd0);
      check("abort.side_rst", {56'd0, oside_a}, 64'd0);
      run_txn(0, 32'd9, 8'h3C, 32'd8, 6, 1'b0, "abort.next");

      // ---------------- Q_W=3, rounding wrap ----------------
      run_txn(1, 32'd9,  8'h00, 32'd4, 5, 1'b0, "b.x9");
      run_txn(1, 32'd16, 8'h00, 32'd0, 5, 1'b0, "b.x16_wrap");

      // ---------------- default 32-bit configuration ----------------
      run_txn(2, 32'd1,          8'h00, 32'd1,          34, 1'b0, "c.x1");
      run_txn(2, 32'hFFFF0000,   8'h00, 32'hFFFFFFFF,   34, 1'b0, "c.xmax");
      run_txn(2, 32'h7FFF8000,   8'h00, 32'h7FFFFFFF,   34, 1'b0, "c.xhalf");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
